fetch_stall_ctrl: RTL and testbench

//  Consumer side of the hazard detector's stall signal. Owns the PC register and the IF/ID pipeline register.

---
 rtl/fetch_stall_ctrl.sv | 155 +++++++++++++++
 tb/tb_fetch_stall_ctrl.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/fetch_stall_ctrl.sv
// Fetch-side stall/redirect consumer: owns the PC and IF/ID registers, applies hazard stalls and ID-stage redirects.
// Optional performance counters are built only when FETCH_PERF_CNT_EN is defined.
module fetch_stall_ctrl #(
    parameter int                    PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0]   RESET_PC  = '0,
    parameter int                    MAX_STALL = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect,
    input  logic [PC_WIDTH-1:0] redirect_pc,
    input  logic [PC_WIDTH-1:0] imem_instr,
    output logic [PC_WIDTH-1:0] pc_out,
    output logic [PC_WIDTH-1:0] if_id_instr,
    output logic [PC_WIDTH-1:0] if_id_pc4,
    output logic                if_id_valid,
    output logic                id_ex_bubble,
    output logic                stall_err,
    output logic [31:0]         stall_cnt,
    output logic [31:0]         flush_cnt
);

    localparam int                RUN_W     = (MAX_STALL + 2 > 2) ? $clog2(MAX_STALL + 2) : 1;
    localparam logic [RUN_W-1:0]  RUN_LIMIT = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0]  RUN_SAT   = RUN_W'(MAX_STALL + 1);

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_REDIRECT,
        OP_ADVANCE
    } fetch_op_e;

    fetch_op_e           fetch_op;
    logic [PC_WIDTH-1:0] pc_p0;
    logic [PC_WIDTH-1:0] pc_plus4;
    logic [PC_WIDTH-1:0] redirect_target;
    logic [PC_WIDTH-1:0] instr_p1;
    logic [PC_WIDTH-1:0] pc4_p1;
    logic                vld_p1;
    logic [RUN_W-1:0]    run_cnt;
    logic                err_q;
    logic                unused_redirect_lsbs;

    // Saturating run-length step for the stall watchdog.
    function automatic logic [RUN_W-1:0] run_step(input logic [RUN_W-1:0] run, input logic stalled);
        if (!stalled)
            return '0;
        else if (run >= RUN_SAT)
            return RUN_SAT;
        else
            return run + RUN_W'(1);
    endfunction

    assign pc_plus4             = pc_p0 + PC_WIDTH'(4);
    assign redirect_target      = {redirect_pc[PC_WIDTH-1:2], 2'b00};
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    // Stall outranks redirect: while stalled the ID operands feeding the branch are stale.
    always_comb begin
        fetch_op = OP_ADVANCE;
        if (stall)
            fetch_op = OP_HOLD;
        else if (redirect)
            fetch_op = OP_REDIRECT;
    end

    // ---- IF stage: PC register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_p0 <= RESET_PC;
        end else begin
            case (fetch_op)
                OP_HOLD:     pc_p0 <= pc_p0;
                OP_REDIRECT: pc_p0 <= redirect_target;
                default:     pc_p0 <= pc_plus4;
            endcase
        end
    end

    // ---- IF/ID boundary ----
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_p1 <= '0;
            pc4_p1   <= '0;
            vld_p1   <= 1'b0;
        end else begin
            case (fetch_op)
                OP_HOLD: begin
                    instr_p1 <= instr_p1;
                    pc4_p1   <= pc4_p1;
                    vld_p1   <= vld_p1;
                end
                OP_REDIRECT: begin
                    instr_p1 <= '0;
                    pc4_p1   <= '0;
                    vld_p1   <= 1'b0;
                end
                default: begin
                    instr_p1 <= imem_instr;
                    pc4_p1   <= pc_plus4;
                    vld_p1   <= 1'b1;
                end
            endcase
        end
    end

    // Watchdog: flag the edge that would extend a stall run past MAX_STALL; sticky until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            run_cnt <= '0;
            err_q   <= 1'b0;
        end else begin
            run_cnt <= run_step(run_cnt, stall);
            if (stall && run_cnt == RUN_LIMIT)
                err_q <= 1'b1;
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] flush_cnt_q;

    function automatic logic [31:0] sat_inc32(input logic [31:0] val, input logic en);
        if (en && val != 32'hFFFF_FFFF)
            return val + 32'd1;
        else
            return val;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= sat_inc32(stall_cnt_q, stall);
            flush_cnt_q <= sat_inc32(flush_cnt_q, redirect & ~stall);
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

    assign pc_out       = pc_p0;
    assign if_id_instr  = instr_p1;
    assign if_id_pc4    = pc4_p1;
    assign if_id_valid  = vld_p1;
    assign id_ex_bubble = stall & ~reset;
    assign stall_err    = err_q;

endmodule

// File: tb/tb_fetch_stall_ctrl.sv
// Directed-vector bench for fetch_stall_ctrl; IMEM is modelled as instr = pc + 0xA0.
module tb_fetch_stall_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_instr;
    logic [31:0] pc_out;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        id_ex_bubble;
    logic        stall_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    fetch_stall_ctrl #(
        .PC_WIDTH (32),
        .RESET_PC (32'h0),
        .MAX_STALL(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_instr  (imem_instr),
        .pc_out      (pc_out),
        .if_id_instr (if_id_instr),
        .if_id_pc4   (if_id_pc4),
        .if_id_valid (if_id_valid),
        .id_ex_bubble(id_ex_bubble),
        .stall_err   (stall_err),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    assign imem_instr = pc_out + 32'hA0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                              input logic [31:0] pc4, input logic vld);
        check_eq({tag, ".pc"},    pc_out,             pc);
        check_eq({tag, ".instr"}, if_id_instr,        instr);
        check_eq({tag, ".pc4"},   if_id_pc4,          pc4);
        check_eq({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, vld});
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tick(2);
        check_ifid("reset", 32'h0, 32'h0, 32'h0, 1'b0);
        check_eq("reset.err",       {31'd0, stall_err}, 32'd0);
        check_eq("reset.stall_cnt", stall_cnt, 32'd0);
        check_eq("reset.flush_cnt", flush_cnt, 32'd0);
        stall = 1'b1; #1;
        check_eq("reset.bubble_masked", {31'd0, id_ex_bubble}, 32'd0);
        stall = 1'b0; reset = 1'b0;

        // Free-running fetch, then single-cycle stall at pc=0x8
        tick(2);
        check_ifid("run2", 32'h8, 32'hA4, 32'h8, 1'b1);
        stall = 1'b1; #1;
        check_eq("stall1.bubble", {31'd0, id_ex_bubble}, 32'd1);
        tick(1);
        check_ifid("stall1.hold", 32'h8, 32'hA4, 32'h8, 1'b1);
        stall = 1'b0; #1;
        check_eq("stall1.bubble_off", {31'd0, id_ex_bubble}, 32'd0);
        tick(1);
        check_ifid("resume", 32'hC, 32'hA8, 32'hC, 1'b1);

        // Redirect at pc=0x20 to misaligned 0x103
        tick(5);
        check_ifid("at20", 32'h20, 32'hBC, 32'h20, 1'b1);
        redirect = 1'b1; redirect_pc = 32'h103;
        tick(1);
        check_ifid("redir", 32'h100, 32'h0, 32'h0, 1'b0);
        redirect = 1'b0;
        tick(1);
        check_ifid("redir.next", 32'h104, 32'h1A0, 32'h104, 1'b1);

        // Stall and redirect together: redirect dropped
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
        tick(1);
        check_ifid("stall_redir", 32'h104, 32'h1A0, 32'h104, 1'b1);
        stall = 1'b0; redirect = 1'b0;
        tick(1);
        check_eq("after_sr.pc", pc_out, 32'h108);

        // Two-cycle stall: legal
        stall = 1'b1;
        tick(2);
        check_eq("stall2.pc",  pc_out, 32'h108);
        check_eq("stall2.err", {31'd0, stall_err}, 32'd0);
        stall = 1'b0;
        tick(1);
        check_eq("stall2.resume_pc", pc_out, 32'h10C);

        // Three-cycle stall: watchdog trips on third edge and stays set
        stall = 1'b1;
        tick(2);
        check_eq("stall3.err_pre", {31'd0, stall_err}, 32'd0);
        tick(1);
        check_eq("stall3.err", {31'd0, stall_err}, 32'd1);
        check_eq("stall3.pc",  pc_out, 32'h10C);
        stall = 1'b0;
        tick(10);
        check_eq("stall3.err_sticky", {31'd0, stall_err}, 32'd1);
        check_eq("stall3.pc_after",   pc_out, 32'h134);

        // Second redirect; perf totals: 7 stalled edges, 2 redirects
        redirect = 1'b1; redirect_pc = 32'h300;
        tick(1);
        redirect = 1'b0;
        check_eq("redir2.pc", pc_out, 32'h300);
        check_eq("perf.stall_cnt", stall_cnt, PERF ? 32'd7 : 32'd0);
        check_eq("perf.flush_cnt", flush_cnt, PERF ? 32'd2 : 32'd0);

        // PC wrap at top of address space
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        tick(1);
        redirect = 1'b0;
        check_eq("wrap.pc_top", pc_out, 32'hFFFF_FFFC);
        tick(1);
        check_ifid("wrap", 32'h0, 32'h9C, 32'h0, 1'b1);
        tick(1);
        check_eq("wrap.pc_next", pc_out, 32'h4);

        // Reset mid-stall with a pending redirect
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h500; reset = 1'b1;
        tick(1);
        check_ifid("rst_mid", 32'h0, 32'h0, 32'h0, 1'b0);
        check_eq("rst_mid.err",       {31'd0, stall_err}, 32'd0);
        check_eq("rst_mid.stall_cnt", stall_cnt, 32'd0);
        check_eq("rst_mid.flush_cnt", flush_cnt, 32'd0);
        stall = 1'b0; redirect = 1'b0; reset = 1'b0;
        tick(1);
        check_ifid("rst_mid.restart", 32'h4, 32'hA0, 32'h4, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
